// File: rtl/stack_lifo.sv
// LIFO stack with registered top-of-stack, occupancy count, full/empty flags
// and sticky overflow/underflow errors. Simultaneous push+pop replaces TOS.
module stack_lifo #(
    parameter int NBITS = 8,
    parameter int DEPTH = 8,
    parameter int NADDR = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [NBITS-1:0] in,
    output logic [NBITS-1:0] out,
    output logic [NADDR-1:0] level,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             unf
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [NADDR-1:0] DEPTH_L = NADDR'(DEPTH);

    logic [NBITS-1:0] mem [0:DEPTH-1];
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_idx;

    // Entry just below the current TOS; only meaningful when level >= 2.
    assign rd_idx = AW'(level - NADDR'(2));

    assign empty = (level == '0);
    assign full  = (level == DEPTH_L);

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = AW'(level);
        if (!rst && !clr && push) begin
            if (pop && level != '0) begin
                wr_en   = 1'b1;
                wr_addr = AW'(level - NADDR'(1));
            end else if (level != DEPTH_L) begin
                wr_en   = 1'b1;
                wr_addr = AW'(level);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            level <= '0;
            out   <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (push && pop && level != '0) begin
            out <= in;
        end else if (push) begin
            // A push+pop on an empty stack lands here as a plain push.
            if (level == DEPTH_L) begin
                ovf <= 1'b1;
            end else begin
                level <= level + NADDR'(1);
                out   <= in;
            end
        end else if (pop) begin
            if (level == '0) begin
                unf <= 1'b1;
            end else if (level == NADDR'(1)) begin
                level <= '0;
                out   <= '0;
            end else begin
                level <= level - NADDR'(1);
                out   <= mem[rd_idx];
            end
        end
    end

endmodule

// File: tb/tb_stack_lifo.sv
// Self-checking bench for stack_lifo: directed test-plan steps followed by
// random traffic, all compared against a queue-based reference model.
module tb_stack_lifo;

    localparam int NBITS = 8;
    localparam int DEPTH = 4;
    localparam int NADDR = 3;

    typedef struct {
        logic [NBITS-1:0] out;
        logic [NADDR-1:0] level;
        logic             empty;
        logic             full;
        logic             ovf;
        logic             unf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             clr = 1'b0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [NBITS-1:0] in = '0;
    logic [NBITS-1:0] out;
    logic [NADDR-1:0] level;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             unf;

    logic [NBITS-1:0] model_q[$];
    logic [NBITS-1:0] model_out = '0;
    logic             model_ovf = 1'b0;
    logic             model_unf = 1'b0;
    exp_t             sb[$];

    int checks = 0;
    int errors = 0;

    stack_lifo #(.NBITS(NBITS), .DEPTH(DEPTH), .NADDR(NADDR)) dut (
        .clk(clk), .rst(rst), .clr(clr), .push(push), .pop(pop), .in(in),
        .out(out), .level(level), .empty(empty), .full(full),
        .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic model_update(input logic r, input logic c, input logic ps,
                                input logic pp, input logic [NBITS-1:0] d);
        exp_t e;
        if (r || c) begin
            model_q.delete();
            model_out = '0;
            model_ovf = 1'b0;
            model_unf = 1'b0;
        end else if (ps && pp && model_q.size() > 0) begin
            model_q[model_q.size()-1] = d;
            model_out = d;
        end else if (ps) begin
            if (model_q.size() == DEPTH) begin
                model_ovf = 1'b1;
            end else begin
                model_q.push_back(d);
                model_out = d;
            end
        end else if (pp) begin
            if (model_q.size() == 0) begin
                model_unf = 1'b1;
            end else begin
                void'(model_q.pop_back());
                model_out = (model_q.size() > 0) ? model_q[model_q.size()-1] : '0;
            end
        end
        e.out   = model_out;
        e.level = NADDR'(model_q.size());
        e.empty = (model_q.size() == 0);
        e.full  = (model_q.size() == DEPTH);
        e.ovf   = model_ovf;
        e.unf   = model_unf;
        sb.push_back(e);
    endtask

    // Drive one cycle, record the expected result, then compare after the edge.
    task automatic step(input logic r, input logic c, input logic ps,
                        input logic pp, input logic [NBITS-1:0] d);
        exp_t e;
        @(negedge clk);
        rst = r; clr = c; push = ps; pop = pp; in = d;
        model_update(r, c, ps, pp, d);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("sb_out",   out,   e.out);
        chk("sb_level", 8'(level), 8'(e.level));
        chk("sb_empty", 8'(empty), 8'(e.empty));
        chk("sb_full",  8'(full),  8'(e.full));
        chk("sb_ovf",   8'(ovf),   8'(e.ovf));
        chk("sb_unf",   8'(unf),   8'(e.unf));
    endtask

    task automatic do_push(input logic [NBITS-1:0] d);
        step(1'b0, 1'b0, 1'b1, 1'b0, d);
    endtask

    task automatic do_pop();
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    endtask

    initial begin
        // Reset
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("rst_out", out, 8'h00);
        chk("rst_level", 8'(level), 8'd0);
        chk("rst_empty", 8'(empty), 8'd1);
        chk("rst_full", 8'(full), 8'd0);
        chk("rst_ovf", 8'(ovf), 8'd0);
        chk("rst_unf", 8'(unf), 8'd0);

        // Fill, overflow, drain
        do_push(8'h11); chk("fill_out1", out, 8'h11);
        do_push(8'h22); chk("fill_out2", out, 8'h22);
        do_push(8'h33); chk("fill_out3", out, 8'h33);
        do_push(8'h44); chk("fill_out4", out, 8'h44);
        chk("fill_level", 8'(level), 8'd4);
        chk("fill_full", 8'(full), 8'd1);
        do_push(8'h55);
        chk("ovf_flag", 8'(ovf), 8'd1);
        chk("ovf_level", 8'(level), 8'd4);
        chk("ovf_out", out, 8'h44);
        do_pop(); chk("drain_out1", out, 8'h33);
        do_pop(); chk("drain_out2", out, 8'h22);
        do_pop(); chk("drain_out3", out, 8'h11);
        do_pop(); chk("drain_out4", out, 8'h00);
        chk("drain_empty", 8'(empty), 8'd1);

        // Underflow
        do_pop();
        chk("unf_flag", 8'(unf), 8'd1);
        chk("unf_level", 8'(level), 8'd0);
        chk("unf_out", out, 8'h00);
        do_push(8'hA5);
        chk("unf_push_out", out, 8'hA5);
        chk("unf_sticky", 8'(unf), 8'd1);

        // Simultaneous push+pop
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        do_push(8'h10);
        do_push(8'h20);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h99);
        chk("pp_level", 8'(level), 8'd2);
        chk("pp_out", out, 8'h99);
        do_pop();
        chk("pp_pop_out", out, 8'h10);
        do_push(8'h21);
        do_push(8'h31);
        do_push(8'h41);
        chk("pp_full", 8'(full), 8'd1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'hC3);
        chk("pp_full_ovf", 8'(ovf), 8'd0);
        chk("pp_full_out", out, 8'hC3);
        do_pop();
        chk("pp_full_pop", out, 8'h31);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h7E);
        chk("pp_empty_level", 8'(level), 8'd1);
        chk("pp_empty_out", out, 8'h7E);
        chk("pp_empty_unf", 8'(unf), 8'd0);

        // Flush and priority
        do_push(8'h01);
        do_push(8'h02);
        do_push(8'h03);
        do_push(8'h04);
        do_pop();
        chk("pre_clr_level", 8'(level), 8'd3);
        chk("pre_clr_ovf", 8'(ovf), 8'd1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'hEE);
        chk("clr_level", 8'(level), 8'd0);
        chk("clr_out", out, 8'h00);
        chk("clr_ovf", 8'(ovf), 8'd0);
        do_push(8'h5A);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
        chk("rstclr_level", 8'(level), 8'd0);
        chk("rstclr_out", out, 8'h00);
        chk("rstclr_unf", 8'(unf), 8'd0);
        chk("rstclr_empty", 8'(empty), 8'd1);

        // Random traffic
        for (int i = 0; i < 10000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 63) == 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
